// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - program loader and bounded-run controller for the single-cycle core
// Streams a program into instruction memory, sequences core reset, and records how the run ended.
module core_run_ctrl #(
  parameter int         DEPTH           = 64,
  parameter int         ADDR_W          = 6,
  parameter int         CYC_W           = 16,
  parameter int         CORE_RST_CYCLES = 4,
  parameter logic [3:0] HALT_OP         = 4'hF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              run_start,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic              abort,
  output logic              store_en,
  output logic [ADDR_W-1:0] store_address,
  output logic [31:0]       store_data,
  output logic              core_rst_n,
  input  logic [31:0]       core_alu_data,
  input  logic [3:0]        core_opcode,
  output logic              busy,
  output logic              done,
  output logic [1:0]        reason,
  output logic [31:0]       result,
  output logic [ADDR_W:0]   ld_count,
  output logic              load_ovf
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CRST, S_RUN, S_DONE} state_t;

  localparam int                RST_W     = $clog2(CORE_RST_CYCLES + 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(CORE_RST_CYCLES - 1);
  localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic                store_en_q, store_en_d;
  logic [ADDR_W-1:0]   store_address_q, store_address_d;
  logic [31:0]         store_data_q, store_data_d;
  logic [ADDR_W:0]     ld_count_q, ld_count_d;
  logic                load_ovf_q, load_ovf_d;
  logic [1:0]          reason_q, reason_d;
  logic [31:0]         result_q, result_d;
  logic [CYC_W-1:0]    run_cycles_q, run_cycles_d;
  logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [RST_W-1:0]    crst_cnt_q, crst_cnt_d;

  always_comb begin
    state_d         = state_q;
    store_en_d      = 1'b0;
    store_address_d = store_address_q;
    store_data_d    = store_data_q;
    ld_count_d      = ld_count_q;
    load_ovf_d      = load_ovf_q;
    reason_d        = reason_q;
    result_d        = result_q;
    run_cycles_d    = run_cycles_q;
    cyc_cnt_d       = cyc_cnt_q;
    crst_cnt_d      = crst_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ld_start) begin
          state_d    = S_LOAD;
          ld_count_d = '0;
          load_ovf_d = 1'b0;
          reason_d   = 2'b00;
        end else if (run_start && (ld_count_q != '0)) begin
          state_d      = S_CRST;
          run_cycles_d = run_cycles;
          reason_d     = 2'b00;
          crst_cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          store_en_d      = 1'b1;
          store_address_d = ld_count_q[ADDR_W-1:0];
          store_data_d    = ld_data;
          ld_count_d      = ld_count_q + 1'b1;
          if (ld_last) begin
            state_d = S_IDLE;
          end else if (ld_count_q == LAST_SLOT) begin
            // Memory is full and the host never marked the end of the program.
            load_ovf_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
        if (abort) state_d = S_IDLE;
      end
      S_CRST: begin
        if (abort) begin
          state_d  = S_DONE;
          reason_d = 2'b11;
        end else if (crst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          cyc_cnt_d = '0;
        end else begin
          crst_cnt_d = crst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        result_d  = core_alu_data;
        cyc_cnt_d = cyc_cnt_q + 1'b1;
        if (abort) begin
          state_d  = S_DONE;
          reason_d = 2'b11;
        end else if (core_opcode == HALT_OP) begin
          state_d  = S_DONE;
          reason_d = 2'b10;
        end else if ((run_cycles_q != '0) && (cyc_cnt_q == run_cycles_q - 1'b1)) begin
          state_d  = S_DONE;
          reason_d = 2'b01;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      store_en_q      <= 1'b0;
      store_address_q <= '0;
      store_data_q    <= '0;
      ld_count_q      <= '0;
      load_ovf_q      <= 1'b0;
      reason_q        <= 2'b00;
      result_q        <= '0;
      run_cycles_q    <= '0;
      cyc_cnt_q       <= '0;
      crst_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      store_en_q      <= store_en_d;
      store_address_q <= store_address_d;
      store_data_q    <= store_data_d;
      ld_count_q      <= ld_count_d;
      load_ovf_q      <= load_ovf_d;
      reason_q        <= reason_d;
      result_q        <= result_d;
      run_cycles_q    <= run_cycles_d;
      cyc_cnt_q       <= cyc_cnt_d;
      crst_cnt_q      <= crst_cnt_d;
    end
  end

  // Status decoded straight from state so reset clears it without waiting for a clock.
  assign ld_ready      = (state_q == S_LOAD);
  assign busy          = (state_q == S_LOAD) || (state_q == S_CRST) || (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign core_rst_n    = (state_q == S_RUN);
  assign store_en      = store_en_q;
  assign store_address = store_address_q;
  assign store_data    = store_data_q;
  assign reason        = reason_q;
  assign result        = result_q;
  assign ld_count      = ld_count_q;
  assign load_ovf      = load_ovf_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - self-checking bench for core_run_ctrl
// Timestamp-based reference model compared every cycle, plus literal checks per scenario.
module tb_core_run_ctrl;
  localparam int         DEPTH = 64;
  localparam int         AW    = 6;
  localparam int         CW    = 16;
  localparam int         CR    = 4;
  localparam logic [3:0] HALT  = 4'hF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready;
  logic          run_start = 1'b0;
  logic [CW-1:0] run_cycles = '0;
  logic          abort = 1'b0;
  logic          store_en;
  logic [AW-1:0] store_address;
  logic [31:0]   store_data;
  logic          core_rst_n;
  logic [31:0]   core_alu_data = '0;
  logic [3:0]    core_opcode = 4'h0;
  logic          busy, done;
  logic [1:0]    reason;
  logic [31:0]   result;
  logic [AW:0]   ld_count;
  logic          load_ovf;

  core_run_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .CYC_W(CW), .CORE_RST_CYCLES(CR), .HALT_OP(HALT)) dut (
    .clk(clk), .reset_n(reset_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .run_start(run_start), .run_cycles(run_cycles),
    .abort(abort), .store_en(store_en), .store_address(store_address), .store_data(store_data),
    .core_rst_n(core_rst_n), .core_alu_data(core_alu_data), .core_opcode(core_opcode),
    .busy(busy), .done(done), .reason(reason), .result(result), .ld_count(ld_count),
    .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int st_pulses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: load bookkeeping plus a run tracked by its start edge and elapsed edges.
  bit          m_loading = 0, m_ovf = 0, m_active = 0, m_done = 0;
  int          m_words = 0, m_t = 0, m_t0 = 0, m_budget = 0;
  logic [1:0]  m_reason = 2'b00;
  logic [31:0] m_result = '0;
  bit          e_st = 0;
  int          e_addr = 0;
  logic [31:0] e_data = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_loading = 0; m_ovf = 0; m_active = 0; m_done = 0; m_words = 0;
      m_t0 = 0; m_budget = 0; m_reason = 2'b00; m_result = '0; e_st = 0;
      e_addr = 0; e_data = '0;
    end else begin
      int el;
      m_t++;
      e_st = 0;
      if (m_loading) begin
        if (ld_valid) begin
          e_st = 1; e_addr = m_words; e_data = ld_data;
          m_words++;
          if (ld_last) m_loading = 0;
          else if (m_words == DEPTH) begin m_ovf = 1; m_loading = 0; end
        end
        if (abort) m_loading = 0;
      end else if (m_active) begin
        el = m_t - m_t0;
        if (el <= CR) begin
          if (abort) begin m_active = 0; m_done = 1; m_reason = 2'b11; end
        end else begin
          m_result = core_alu_data;
          if (abort) begin m_active = 0; m_done = 1; m_reason = 2'b11; end
          else if (core_opcode == HALT) begin m_active = 0; m_done = 1; m_reason = 2'b10; end
          else if (m_budget != 0 && (el - CR) == m_budget) begin
            m_active = 0; m_done = 1; m_reason = 2'b01;
          end
        end
      end else if (ld_start) begin
        m_loading = 1; m_words = 0; m_ovf = 0; m_done = 0; m_reason = 2'b00;
      end else if (run_start && m_words != 0) begin
        m_active = 1; m_t0 = m_t; m_budget = int'(run_cycles); m_done = 0; m_reason = 2'b00;
      end
    end
  end

  always @(negedge clk) begin
    chk("core_rst_n", 32'(core_rst_n), 32'(m_active && (m_t - m_t0) >= CR));
    chk("busy", 32'(busy), 32'(m_loading || m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("ld_ready", 32'(ld_ready), 32'(m_loading));
    chk("reason", 32'(reason), 32'(m_reason));
    chk("result", result, m_result);
    chk("ld_count", 32'(ld_count), m_words);
    chk("load_ovf", 32'(load_ovf), 32'(m_ovf));
    chk("store_en", 32'(store_en), 32'(e_st));
    if (e_st) begin
      chk("store_address", 32'(store_address), e_addr);
      chk("store_data", store_data, e_data);
    end
    if (store_en) st_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input bit with_last, input logic [31:0] base);
    ld_start = 1; tick(); ld_start = 0;
    for (int i = 0; i < n; i++) begin
      ld_valid = 1; ld_data = base + 32'(i); ld_last = with_last && (i == n - 1);
      tick();
    end
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic start_run(input int n);
    run_cycles = CW'(n); run_start = 1; tick(); run_start = 0;
  endtask

  initial begin
    int p0, lo, hi, i;
    repeat (3) tick();
    chk("reset_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_n = 1;
    tick();

    // Three-word program
    p0 = st_pulses;
    load(3, 1, 32'hA);
    tick();
    chk("load3_count", 32'(ld_count), 32'd3);
    chk("load3_ovf", 32'(load_ovf), 32'd0);
    chk("load3_pulses", st_pulses - p0, 32'd3);
    chk("load3_busy", 32'(busy), 32'd0);

    // Fill memory without ld_last
    p0 = st_pulses;
    load(64, 0, 32'h5500_0000);
    tick();
    chk("fill_pulses", st_pulses - p0, 32'd64);
    chk("fill_ovf", 32'(load_ovf), 32'd1);
    chk("fill_ready", 32'(ld_ready), 32'd0);
    chk("fill_count", 32'(ld_count), 32'd64);

    // Budgeted run of 10 cycles
    start_run(10);
    lo = 0; hi = 0;
    for (i = 0; i < 40 && !done; i++) begin
      core_alu_data = 32'hA000_0000 + 32'(i);
      if (core_rst_n) hi++; else lo++;
      tick();
    end
    chk("budget_done", 32'(done), 32'd1);
    chk("budget_low_cycles", lo, 32'd4);
    chk("budget_high_cycles", hi, 32'd10);
    chk("budget_reason", 32'(reason), 32'd1);
    chk("budget_result", result, 32'hA000_000D);

    // Unlimited run halted on the fifth RUN cycle
    start_run(0);
    hi = 0;
    for (i = 0; i < 40 && !done; i++) begin
      if (core_rst_n) hi++;
      if (hi == 5) begin core_opcode = HALT; core_alu_data = 32'h1234; end
      else core_alu_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    core_opcode = 4'h0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_cycles", hi, 32'd5);
    chk("halt_reason", 32'(reason), 32'd2);
    chk("halt_result", result, 32'h1234);

    // Abort and halt together in RUN
    start_run(0);
    for (i = 0; i < 20 && !core_rst_n; i++) tick();
    chk("abort_run_reached", 32'(core_rst_n), 32'd1);
    abort = 1; core_opcode = HALT; tick();
    abort = 0; core_opcode = 4'h0;
    chk("abort_run_reason", 32'(reason), 32'd3);
    chk("abort_run_done", 32'(done), 32'd1);

    // Abort during core reset
    start_run(5);
    abort = 1; tick(); abort = 0;
    chk("abort_crst_reason", 32'(reason), 32'd3);
    chk("abort_crst_rst_n", 32'(core_rst_n), 32'd0);

    // Abort mid-load after two words
    ld_start = 1; tick(); ld_start = 0;
    for (int k = 0; k < 2; k++) begin ld_valid = 1; ld_data = 32'h77 + 32'(k); tick(); end
    ld_valid = 0; abort = 1; tick(); abort = 0; tick();
    chk("abort_load_count", 32'(ld_count), 32'd2);
    chk("abort_load_reason", 32'(reason), 32'd0);
    chk("abort_load_busy", 32'(busy), 32'd0);
    chk("abort_load_done", 32'(done), 32'd0);

    // Asynchronous reset during RUN
    start_run(0);
    for (i = 0; i < 20 && !core_rst_n; i++) tick();
    #2 reset_n = 0;
    #1;
    chk("rst_run_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_run_busy", 32'(busy), 32'd0);
    chk("rst_run_count", 32'(ld_count), 32'd0);
    chk("rst_run_result", result, 32'd0);
    tick(); reset_n = 1; tick();

    // Asynchronous reset during a store pulse
    ld_start = 1; tick(); ld_start = 0;
    ld_valid = 1; ld_data = 32'hFACE; tick(); ld_valid = 0;
    chk("pulse_before_rst", 32'(store_en), 32'd1);
    #1 reset_n = 0;
    #1;
    chk("pulse_dropped", 32'(store_en), 32'd0);
    chk("pulse_addr_zero", 32'(store_address), 32'd0);
    chk("pulse_data_zero", store_data, 32'd0);
    tick(); reset_n = 1; tick();

    // run_start with an empty program is ignored
    start_run(3);
    repeat (3) tick();
    chk("empty_run_busy", 32'(busy), 32'd0);
    chk("empty_run_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("empty_run_done", 32'(done), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
